fp_mac_arbiter: RTL and testbench

- Shares one combinational fp_mac datapath among NREQ requesters.
- Arbitration is round-robin. Operands are registered into a single issue stage that drives the shared MAC.
- Each requester has a one-entry response buffer. A requester is issued only when its buffer has room, so the issue stage never stalls and there is no head-of-line blocking.
- Sits between the FPU's multi-operand sequencers (fma/div/sqrt iteration units) and the single shared fp_mac instance.

---
 rtl/fp_mac_arbiter.sv | 133 +++++++++++++
 tb/tb_fp_mac_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mac_arbiter.sv
// Round-robin arbiter that shares one combinational fp_mac among NREQ requesters.
// A single issue stage feeds the MAC, and each requester has a one-entry response buffer.
module fp_mac_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*27-1:0] req_a,
    input  logic [NREQ*27-1:0] req_b,
    input  logic [NREQ*27-1:0] req_c,
    input  logic [NREQ-1:0]    req_op,
    output logic [NREQ-1:0]    resp_valid,
    input  logic [NREQ-1:0]    resp_ready,
    output logic [NREQ*52-1:0] resp_d,
    output logic [26:0]        mac_a,
    output logic [26:0]        mac_b,
    output logic [26:0]        mac_c,
    output logic               mac_op,
    input  logic [51:0]        mac_d,
    output logic               busy
);

    localparam int AW = 27;
    localparam int DW = 52;

    logic               s1_valid_q, s1_valid_d;
    logic [IDW-1:0]     s1_id_q, s1_id_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]      mac_a_q, mac_a_d;
    logic [AW-1:0]      mac_b_q, mac_b_d;
    logic [AW-1:0]      mac_c_q, mac_c_d;
    logic               mac_op_q, mac_op_d;
    logic [NREQ-1:0]    resp_valid_q, resp_valid_d;
    logic [NREQ*DW-1:0] resp_d_q, resp_d_d;

    logic [NREQ-1:0]    eligible;
    logic               grant_any;
    logic [IDW-1:0]     grant_id;

    // Both operands are below NREQ, so one conditional subtract wraps the sum.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NREQ) sum = sum - NREQ;
        return IDW'(sum);
    endfunction

    // A requester is blocked while its op is in S1 or its buffer is full.
    // That is why S1 never stalls: the buffer slot is always free at retire.
    always_comb begin : grant_logic
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        eligible  = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] & ~resp_valid_q[i]
                          & ~(s1_valid_q & (s1_id_q == IDW'(i)));
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && eligible[rr_index(rr_ptr_q, k)]) begin
                grant_any = 1'b1;
                grant_id  = rr_index(rr_ptr_q, k);
            end
        end
        if (grant_any) req_ready[grant_id] = 1'b1;
    end

    always_comb begin : next_state
        s1_valid_d   = grant_any;
        s1_id_d      = s1_id_q;
        rr_ptr_d     = rr_ptr_q;
        mac_a_d      = mac_a_q;
        mac_b_d      = mac_b_q;
        mac_c_d      = mac_c_q;
        mac_op_d     = mac_op_q;
        resp_valid_d = resp_valid_q & ~resp_ready;
        resp_d_d     = resp_d_q;

        if (grant_any) begin
            s1_id_d  = grant_id;
            rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            mac_a_d  = req_a[AW*int'(grant_id) +: AW];
            mac_b_d  = req_b[AW*int'(grant_id) +: AW];
            mac_c_d  = req_c[AW*int'(grant_id) +: AW];
            mac_op_d = req_op[grant_id];
        end

        // The consume-clear above cannot hit this slot, because the slot was empty at grant.
        if (s1_valid_q) begin
            resp_valid_d[s1_id_q]               = 1'b1;
            resp_d_d[DW*int'(s1_id_q) +: DW]    = mac_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_id_q      <= '0;
            rr_ptr_q     <= '0;
            mac_a_q      <= '0;
            mac_b_q      <= '0;
            mac_c_q      <= '0;
            mac_op_q     <= 1'b0;
            resp_valid_q <= '0;
            // NOTE: the result buffers are reset because they drive resp_d directly and must read zero out of reset.
            resp_d_q     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            rr_ptr_q     <= rr_ptr_d;
            mac_a_q      <= mac_a_d;
            mac_b_q      <= mac_b_d;
            mac_c_q      <= mac_c_d;
            mac_op_q     <= mac_op_d;
            resp_valid_q <= resp_valid_d;
            resp_d_q     <= resp_d_d;
        end
    end

    assign mac_a      = mac_a_q;
    assign mac_b      = mac_b_q;
    assign mac_c      = mac_c_q;
    assign mac_op     = mac_op_q;
    assign resp_valid = resp_valid_q;
    assign resp_d     = resp_d_q;
    assign busy       = s1_valid_q | (|resp_valid_q);

endmodule

// File: tb/tb_fp_mac_arbiter.sv
// Directed and random checks for fp_mac_arbiter, with a behavioural fp_mac in the loop.
module tb_fp_mac_arbiter;

    localparam int NREQ = 4;

    logic               clock;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*27-1:0] req_a, req_b, req_c;
    logic [NREQ-1:0]    req_op;
    logic [NREQ-1:0]    resp_valid;
    logic [NREQ-1:0]    resp_ready;
    logic [NREQ*52-1:0] resp_d;
    logic [26:0]        mac_a, mac_b, mac_c;
    logic               mac_op;
    logic [51:0]        mac_d;
    logic               busy;

    int tests_run    = 0;
    int tests_failed = 0;

    fp_mac_arbiter #(.NREQ(NREQ)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_d     (resp_d),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_c      (mac_c),
        .mac_op     (mac_op),
        .mac_d      (mac_d),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [51:0] mac_model(input logic [26:0] a, input logic [26:0] b,
                                              input logic [26:0] c, input logic op);
        logic signed [53:0] sb, sc, p;
        logic [51:0] pl;
        sb = {{27{b[26]}}, b};
        sc = {{27{c[26]}}, c};
        p  = sb * sc;
        pl = p[51:0];
        return {a, 25'b0} + (op ? (52'd0 - pl) : pl);
    endfunction

    always_comb mac_d = mac_model(mac_a, mac_b, mac_c, mac_op);

    task automatic set_req(input int i, input logic [26:0] a, input logic [26:0] b,
                           input logic [26:0] c, input logic op);
        req_a[27*i +: 27] = a;
        req_b[27*i +: 27] = b;
        req_c[27*i +: 27] = c;
        req_op[i]         = op;
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        req_c      = '0;
        req_op     = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        req_a = '0; req_b = '0; req_c = '0; req_op = '0;
        @(negedge clock);
        #1;
        tests_run++;
        if ({resp_valid, busy, mac_op, req_ready} !== 10'b0) begin
            $display("FAIL reset_ctrl: got %b required 0", {resp_valid, busy, mac_op, req_ready});
            tests_failed++;
        end
        tests_run++;
        if ({mac_a, mac_b, mac_c} !== 81'b0 || resp_d !== '0) begin
            $display("FAIL reset_data: mac_a=%h resp_d=%h required 0", mac_a, resp_d);
            tests_failed++;
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_one(input logic [26:0] a, input logic [26:0] b, input logic [26:0] c,
                           input logic op, input logic [51:0] exp_d);
        @(negedge clock);
        set_req(0, a, b, c, op);
        req_valid  = 4'b0001;
        resp_ready = '0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001 || busy !== 1'b0) begin
            $display("FAIL single_grant: req_ready=%b busy=%b required 0001/0", req_ready, busy);
            tests_failed++;
        end
        @(negedge clock);
        req_valid = '0;
        #1;
        tests_run++;
        if (mac_a !== a || mac_b !== b || mac_c !== c || mac_op !== op) begin
            $display("FAIL single_mac: got %h %h %h %b required %h %h %h %b",
                     mac_a, mac_b, mac_c, mac_op, a, b, c, op);
            tests_failed++;
        end
        tests_run++;
        if (busy !== 1'b1 || resp_valid !== 4'b0000) begin
            $display("FAIL single_s1: busy=%b resp_valid=%b required 1/0000", busy, resp_valid);
            tests_failed++;
        end
        @(negedge clock);
        #1;
        tests_run++;
        if (resp_valid !== 4'b0001 || resp_d[51:0] !== exp_d || busy !== 1'b1) begin
            $display("FAIL single_resp: valid=%b d=%h busy=%b required 0001 %h 1",
                     resp_valid, resp_d[51:0], busy, exp_d);
            tests_failed++;
        end
        resp_ready = 4'b0001;
        @(negedge clock);
        resp_ready = '0;
        #1;
        tests_run++;
        if (resp_valid !== 4'b0000 || busy !== 1'b0 || resp_d[51:0] !== exp_d) begin
            $display("FAIL single_consume: valid=%b busy=%b d=%h required 0000 0 %h",
                     resp_valid, busy, resp_d[51:0], exp_d);
            tests_failed++;
        end
    endtask

    task automatic test_single;
        do_reset();
        run_one(27'd1, 27'd2, 27'd3, 1'b0, 52'h2000006);
        run_one(27'd1, 27'd2, 27'd3, 1'b1, 52'h1FFFFFA);
        run_one(27'd0, 27'h7FFFFFF, 27'd1, 1'b0, 52'hFFFFFFFFFFFFF);
    endtask

    // Requester 0: 5<<25 + 77; requester 1: 2<<25 - (-12).
    task automatic test_alternate;
        logic [3:0] exp_g;
        logic [3:0] exp_v;
        do_reset();
        set_req(0, 27'd5, 27'd7, 27'd11, 1'b0);
        set_req(1, 27'd2, 27'h7FFFFFD, 27'd4, 1'b1);
        resp_ready = 4'b0011;
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            req_valid = 4'b0011;
            #1;
            exp_g = (k % 3 == 0) ? 4'b0001 : (k % 3 == 1) ? 4'b0010 : 4'b0000;
            exp_v = (k % 3 == 2) ? 4'b0001 : (k % 3 == 0 && k > 0) ? 4'b0010 : 4'b0000;
            tests_run++;
            if (req_ready !== exp_g) begin
                $display("FAIL alt_grant[%0d]: got %b required %b", k, req_ready, exp_g);
                tests_failed++;
            end
            tests_run++;
            if (resp_valid !== exp_v) begin
                $display("FAIL alt_valid[%0d]: got %b required %b", k, resp_valid, exp_v);
                tests_failed++;
            end
            if (exp_v[0]) begin
                tests_run++;
                if (resp_d[51:0] !== 52'hA00004D) begin
                    $display("FAIL alt_d0[%0d]: got %h required a00004d", k, resp_d[51:0]);
                    tests_failed++;
                end
            end
            if (exp_v[1]) begin
                tests_run++;
                if (resp_d[103:52] !== 52'h400000C) begin
                    $display("FAIL alt_d1[%0d]: got %h required 400000c", k, resp_d[103:52]);
                    tests_failed++;
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        logic [3:0] exp_g [11];
        exp_g = '{4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0000,
                  4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
        do_reset();
        set_req(0, 27'd5, 27'd7, 27'd11, 1'b0);
        set_req(1, 27'd2, 27'h7FFFFFD, 27'd4, 1'b1);
        for (int k = 0; k < 11; k++) begin
            @(negedge clock);
            req_valid  = 4'b0011;
            resp_ready = (k == 9) ? 4'b0011 : 4'b0001;
            #1;
            tests_run++;
            if (req_ready !== exp_g[k]) begin
                $display("FAIL bp_grant[%0d]: got %b required %b", k, req_ready, exp_g[k]);
                tests_failed++;
            end
            if (k >= 3) begin
                tests_run++;
                if (resp_valid[1] !== (k <= 9)) begin
                    $display("FAIL bp_hold[%0d]: got %b required %b", k, resp_valid[1], (k <= 9));
                    tests_failed++;
                end
            end
            if (k == 3) begin
                tests_run++;
                if (resp_d[103:52] !== 52'h400000C) begin
                    $display("FAIL bp_d1: got %h required 400000c", resp_d[103:52]);
                    tests_failed++;
                end
            end
        end
        req_valid  = '0;
        resp_ready = '0;
    endtask

    task automatic test_reset_async;
        do_reset();
        set_req(0, 27'd1, 27'd1, 27'd1, 1'b0);
        set_req(1, 27'd2, 27'd2, 27'd2, 1'b0);
        set_req(2, 27'd3, 27'd1, 27'd1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            req_valid = 4'b0111;
        end
        #1;
        tests_run++;
        if (resp_valid !== 4'b0011 || busy !== 1'b1 || req_ready !== 4'b0000) begin
            $display("FAIL arst_setup: valid=%b busy=%b ready=%b required 0011 1 0000",
                     resp_valid, busy, req_ready);
            tests_failed++;
        end
        #2;
        reset     = 1'b1;
        req_valid = '0;
        #1;
        tests_run++;
        if (resp_valid !== '0 || resp_d !== '0 || busy !== 1'b0 || req_ready !== '0) begin
            $display("FAIL arst_resp: valid=%b busy=%b d=%h required all 0", resp_valid, busy, resp_d);
            tests_failed++;
        end
        tests_run++;
        if (mac_a !== '0 || mac_b !== '0 || mac_c !== '0 || mac_op !== 1'b0) begin
            $display("FAIL arst_mac: got %h %h %h %b required 0", mac_a, mac_b, mac_c, mac_op);
            tests_failed++;
        end
        @(negedge clock);
        reset     = 1'b0;
        req_valid = 4'b0011;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL arst_first_grant: got %b required 0001", req_ready);
            tests_failed++;
        end
        @(negedge clock);
        req_valid = '0;
        @(negedge clock);
        #1;
        tests_run++;
        if (resp_valid !== 4'b0001) begin
            $display("FAIL arst_discard: got %b required 0001", resp_valid);
            tests_failed++;
        end
    endtask

    // Reference model: stage 0 idle, 1 in issue stage, 2 waiting in response buffer.
    task automatic test_stress;
        int          stage [NREQ];
        int          wait_cnt [NREQ];
        logic [51:0] exp_d [NREQ];
        int          ptr;
        int          max_wait;
        int          idx;
        logic [3:0]  elig;
        logic [3:0]  exp_g;
        do_reset();
        ptr = 0;
        for (int i = 0; i < NREQ; i++) begin
            stage[i] = 0;
            wait_cnt[i] = 0;
            exp_d[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clock);
            req_valid  = 4'($urandom_range(0, 15));
            resp_ready = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 27'($urandom), 27'($urandom), 27'($urandom), 1'($urandom_range(0, 1)));
            end
            #1;
            exp_g = '0;
            for (int i = 0; i < NREQ; i++) elig[i] = req_valid[i] && (stage[i] == 0);
            for (int k = 0; k < NREQ; k++) begin
                idx = (ptr + k) % NREQ;
                if (exp_g == '0 && elig[idx]) exp_g[idx] = 1'b1;
            end
            tests_run++;
            if (req_ready !== exp_g) begin
                $display("FAIL stress_grant[%0d]: got %b required %b", cyc, req_ready, exp_g);
                tests_failed++;
            end
            for (int i = 0; i < NREQ; i++) begin
                tests_run++;
                if (resp_valid[i] !== (stage[i] == 2)) begin
                    $display("FAIL stress_valid[%0d][%0d]: got %b required %b",
                             cyc, i, resp_valid[i], (stage[i] == 2));
                    tests_failed++;
                end
                if (stage[i] == 2) begin
                    tests_run++;
                    if (resp_d[52*i +: 52] !== exp_d[i]) begin
                        $display("FAIL stress_d[%0d][%0d]: got %h required %h",
                                 cyc, i, resp_d[52*i +: 52], exp_d[i]);
                        tests_failed++;
                    end
                end
            end
            max_wait = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (elig[i] && !req_ready[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
            tests_run++;
            if (max_wait > NREQ) begin
                $display("FAIL stress_fair[%0d]: waited %0d cycles, limit %0d", cyc, max_wait, NREQ);
                tests_failed++;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (stage[i] == 2 && resp_ready[i]) stage[i] = 0;
                else if (stage[i] == 1) stage[i] = 2;
                if (exp_g[i]) begin
                    stage[i] = 1;
                    exp_d[i] = mac_model(req_a[27*i +: 27], req_b[27*i +: 27],
                                         req_c[27*i +: 27], req_op[i]);
                    ptr = (i + 1) % NREQ;
                end
            end
        end
        req_valid  = '0;
        resp_ready = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_reset_async();
        test_stress();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
